bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter_if.sv | 40 ++++
 rtl/bram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Bundle shared by two requesters and one BRAM port behind bram_port_arbiter.
// The slave modport is the arbiter's view, and the master modport is the requesters' and BRAM's view.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  // Handshake: a requester holds req_k (with addr/wdata/wen/lock stable) until
  // it sees gnt_k; the access transfers on the cycle where req_k && gnt_k.
  // Read data comes back two cycles later on rdata_k, qualified by rvalid_k.
  logic              req_0, req_1;
  logic              lock_0, lock_1;
  logic [ADDR_W-1:0] addr_0, addr_1;
  logic [DATA_W-1:0] wdata_0, wdata_1;
  logic [3:0]        wen_0, wen_1;
  logic              gnt_0, gnt_1;
  logic [DATA_W-1:0] rdata_0, rdata_1;
  logic              rvalid_0, rvalid_1;

  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] bram_din;
  logic [3:0]        bram_wen;
  logic              bram_en;
  logic              bram_clk;
  logic              bram_rst;

  modport slave (
    input  req_0, req_1, lock_0, lock_1, addr_0, addr_1, wdata_0, wdata_1,
           wen_0, wen_1, bram_din,
    output gnt_0, gnt_1, rdata_0, rdata_1, rvalid_0, rvalid_1,
           bram_addr, bram_dout, bram_wen, bram_en, bram_clk, bram_rst
  );

  modport master (
    output req_0, req_1, lock_0, lock_1, addr_0, addr_1, wdata_0, wdata_1,
           wen_0, wen_1, bram_din,
    input  gnt_0, gnt_1, rdata_0, rdata_1, rvalid_0, rvalid_1,
           bram_addr, bram_dout, bram_wen, bram_en, bram_clk, bram_rst
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for one BRAM port. It supports lock bursts, which are bounded
// by LOCK_MAX, and a fully pipelined two-cycle read return.
module bram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                CLK,
  input  logic                RST,
  bram_port_arbiter_if.slave  bus,
  output logic [1:0]          dbgState
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arbStateT;

  arbStateT          state;
  logic              ptr;
  logic [CW-1:0]     lockCnt;
  logic              rstDly;
  logic              gnt0, gnt1;
  logic              enQ;
  logic [3:0]        wenQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] doutQ;
  logic              rdPend0, rdPend1, rv0, rv1;
  logic [DATA_W-1:0] hold0, hold1;

  wire           cntFull = (lockCnt == CW'(LOCK_MAX));
  wire [CW-1:0]  lockInc = lockCnt + CW'(1);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST && !rstDly) begin
      unique case (state)
        OWN0: begin
          if (cntFull && bus.req_1) gnt1 = 1'b1;
          else if (bus.req_0)       gnt0 = 1'b1;
        end
        OWN1: begin
          if (cntFull && bus.req_0) gnt0 = 1'b1;
          else if (bus.req_1)       gnt1 = 1'b1;
        end
        default: begin
          // On a tie, the requester that was not granted last wins.
          if (bus.req_0 && (!bus.req_1 || ptr)) gnt0 = 1'b1;
          else if (bus.req_1)                   gnt1 = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= 1'b1;
      lockCnt <= '0;
      rstDly  <= 1'b1;
      enQ     <= 1'b0;
      wenQ    <= '0;
      addrQ   <= '0;
      doutQ   <= '0;
      rdPend0 <= 1'b0;
      rdPend1 <= 1'b0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
      hold0   <= '0;
      hold1   <= '0;
    end else begin
      rstDly <= 1'b0;
      // The lock counter counts every cycle in which the owner holds the port while the other requester waits.
      if (gnt0) begin
        ptr     <= 1'b0;
        state   <= bus.lock_0 ? OWN0 : IDLE;
        lockCnt <= (bus.lock_0 && bus.req_1) ? ((state == OWN0) ? lockInc : CW'(1)) : '0;
      end else if (gnt1) begin
        ptr     <= 1'b1;
        state   <= bus.lock_1 ? OWN1 : IDLE;
        lockCnt <= (bus.lock_1 && bus.req_0) ? ((state == OWN1) ? lockInc : CW'(1)) : '0;
      end else if (state == OWN0) begin
        if (!bus.lock_0) begin
          state   <= IDLE;
          ptr     <= 1'b0;
          lockCnt <= '0;
        end else begin
          lockCnt <= bus.req_1 ? lockInc : '0;
        end
      end else if (state == OWN1) begin
        if (!bus.lock_1) begin
          state   <= IDLE;
          ptr     <= 1'b1;
          lockCnt <= '0;
        end else begin
          lockCnt <= bus.req_0 ? lockInc : '0;
        end
      end

      enQ     <= gnt0 | gnt1;
      wenQ    <= gnt0 ? bus.wen_0 : (gnt1 ? bus.wen_1 : 4'd0);
      if (gnt0) begin
        addrQ <= bus.addr_0;
        doutQ <= bus.wdata_0;
      end else if (gnt1) begin
        addrQ <= bus.addr_1;
        doutQ <= bus.wdata_1;
      end
      rdPend0 <= gnt0 && (bus.wen_0 == 4'd0);
      rdPend1 <= gnt1 && (bus.wen_1 == 4'd0);
      rv0     <= rdPend0;
      rv1     <= rdPend1;
      if (rv0) hold0 <= bus.bram_din;
      if (rv1) hold1 <= bus.bram_din;
    end
  end

  // While reset is asserted, the outputs are forced to zero before the registers clear at the edge.
  assign bus.gnt_0     = gnt0;
  assign bus.gnt_1     = gnt1;
  assign bus.bram_en   = enQ & ~RST;
  assign bus.bram_wen  = RST ? 4'd0 : wenQ;
  assign bus.bram_addr = RST ? '0 : addrQ;
  assign bus.bram_dout = RST ? '0 : doutQ;
  assign bus.rvalid_0  = rv0 & ~RST;
  assign bus.rvalid_1  = rv1 & ~RST;
  assign bus.rdata_0   = RST ? '0 : (rv0 ? bus.bram_din : hold0);
  assign bus.rdata_1   = RST ? '0 : (rv1 ? bus.bram_din : hold1);
  assign bus.bram_clk  = CLK;
  assign bus.bram_rst  = RST;
  assign dbgState      = state;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter. A behavioural BRAM model sits behind the port.
module tb_bram_port_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  dbg_state;
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [0:16383];
  logic [31:0] exp_q[$];

  bram_port_arbiter_if bus ();

  bram_port_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus.slave),
    .dbgState (dbg_state)
  );

  // clock / memory model
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin : bram_model
    logic [31:0] w;
    if (bus.bram_en) begin
      if (bus.bram_wen == 4'd0) begin
        bus.bram_din <= mem[bus.bram_addr];
      end else begin
        w = mem[bus.bram_addr];
        for (int b = 0; b < 4; b++)
          if (bus.bram_wen[b]) w[8*b +: 8] = bus.bram_dout[8*b +: 8];
        mem[bus.bram_addr] <= w;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.req_0 = 1'b0;   bus.req_1 = 1'b0;
    bus.lock_0 = 1'b0;  bus.lock_1 = 1'b0;
    bus.addr_0 = '0;    bus.addr_1 = '0;
    bus.wdata_0 = '0;   bus.wdata_1 = '0;
    bus.wen_0 = 4'd0;   bus.wen_1 = 4'd0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    mem[14'h0010] = 32'hDEADBEEF;
    idle_inputs();
    RST = 1'b1;

    // reset state
    settle();
    check("rst_gnt0", bus.gnt_0, 0);
    check("rst_gnt1", bus.gnt_1, 0);
    check("rst_en", bus.bram_en, 0);
    check("rst_wen", bus.bram_wen, 0);
    check("rst_addr", bus.bram_addr, 0);
    check("rst_dout", bus.bram_dout, 0);
    check("rst_rvalid0", bus.rvalid_0, 0);
    check("rst_rdata0", bus.rdata_0, 0);
    tick();
    tick();
    RST = 1'b0;
    bus.req_0 = 1'b1;
    bus.addr_0 = 14'h0010;
    settle();
    check("post_rst_gnt0", bus.gnt_0, 0);
    check("post_rst_en", bus.bram_en, 0);
    check("post_rst_rvalid0", bus.rvalid_0, 0);
    check("post_rst_state", dbg_state, 2'd0);
    tick();

    // single read
    settle();
    check("rd_gnt0", bus.gnt_0, 1);
    check("rd_gnt1", bus.gnt_1, 0);
    tick();
    bus.req_0 = 1'b0;
    settle();
    check("rd_en", bus.bram_en, 1);
    check("rd_addr", bus.bram_addr, 14'h0010);
    check("rd_wen", bus.bram_wen, 0);
    check("rd_early_rvalid", bus.rvalid_0, 0);
    tick();
    settle();
    check("rd_rvalid0", bus.rvalid_0, 1);
    check("rd_rdata0", bus.rdata_0, 32'hDEADBEEF);
    check("rd_rvalid1", bus.rvalid_1, 0);
    tick();
    settle();
    check("rd_rvalid_pulse", bus.rvalid_0, 0);
    check("rd_rdata_hold", bus.rdata_0, 32'hDEADBEEF);
    tick();

    // write
    bus.req_1 = 1'b1;
    bus.addr_1 = 14'h3FFF;
    bus.wdata_1 = 32'h12345678;
    bus.wen_1 = 4'hF;
    settle();
    check("wr_gnt1", bus.gnt_1, 1);
    check("wr_gnt0", bus.gnt_0, 0);
    tick();
    bus.req_1 = 1'b0;
    bus.wen_1 = 4'd0;
    settle();
    check("wr_en", bus.bram_en, 1);
    check("wr_wen", bus.bram_wen, 4'hF);
    check("wr_addr", bus.bram_addr, 14'h3FFF);
    check("wr_dout", bus.bram_dout, 32'h12345678);
    tick();
    settle();
    check("wr_no_rvalid_a", bus.rvalid_1, 0);
    check("wr_mem", mem[14'h3FFF], 32'h12345678);
    tick();
    settle();
    check("wr_no_rvalid_b", bus.rvalid_1, 0);
    tick();

    // round robin with both requesters reading back to back
    do_reset();
    bus.addr_0 = 14'h0010;
    bus.addr_1 = 14'h3FFF;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    for (int i = 0; i < 6; i++) begin
      bus.req_0 = (i < 4);
      bus.req_1 = (i < 4);
      settle();
      if (i < 4) begin
        check("rr_gnt0", bus.gnt_0, (i % 2 == 0));
        check("rr_gnt1", bus.gnt_1, (i % 2 == 1));
      end
      if (i >= 1 && i <= 4) check("rr_en", bus.bram_en, 1);
      check("rr_rvalid0", bus.rvalid_0, (i == 2 || i == 4));
      check("rr_rvalid1", bus.rvalid_1, (i == 3 || i == 5));
      if (bus.rvalid_0 || bus.rvalid_1) begin
        if (exp_q.size() == 0)
          check("rr_extra_rvalid", {bus.rvalid_0, bus.rvalid_1}, 0);
        else
          check("rr_rdata", bus.rvalid_0 ? bus.rdata_0 : bus.rdata_1, exp_q.pop_front());
      end
      tick();
    end
    check("rr_q_empty", exp_q.size(), 0);
    exp_q.delete();

    // starvation bound under lock
    do_reset();
    bus.req_0 = 1'b1;
    bus.lock_0 = 1'b1;
    bus.req_1 = 1'b1;
    bus.addr_0 = 14'h0010;
    bus.addr_1 = 14'h0010;
    for (int i = 0; i < 17; i++) begin
      settle();
      check("lock_gnt0", bus.gnt_0, (i < 16));
      check("lock_gnt1", bus.gnt_1, (i == 16));
      if (i == 8) check("lock_state", dbg_state, 2'd1);
      tick();
    end
    bus.lock_0 = 1'b0;
    settle();
    check("lock_next_tie", bus.gnt_0, 1);
    tick();
    idle_inputs();

    // idle owner holds the port
    do_reset();
    bus.req_0 = 1'b1;
    bus.lock_0 = 1'b1;
    settle();
    check("idle_own_take", bus.gnt_0, 1);
    tick();
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      settle();
      check("idle_own_gnt1", bus.gnt_1, (i == 16));
      tick();
    end
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b0;
    settle();
    check("reown_gnt0", bus.gnt_0, 1);
    tick();
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("held_gnt1", bus.gnt_1, 0);
      tick();
    end
    bus.lock_0 = 1'b0;
    settle();
    check("release_gnt1", bus.gnt_1, 0);
    check("release_state", dbg_state, 2'd1);
    tick();
    settle();
    check("after_release_gnt1", bus.gnt_1, 1);
    check("after_release_state", dbg_state, 2'd0);
    tick();
    idle_inputs();

    // reset pulse right after a read grant
    do_reset();
    bus.req_0 = 1'b1;
    bus.addr_0 = 14'h0010;
    settle();
    check("mid_gnt0", bus.gnt_0, 1);
    tick();
    bus.req_0 = 1'b0;
    RST = 1'b1;
    settle();
    check("mid_rst_en", bus.bram_en, 0);
    check("mid_rst_gnt0", bus.gnt_0, 0);
    tick();
    RST = 1'b0;
    bus.req_0 = 1'b1;
    bus.req_1 = 1'b1;
    settle();
    check("mid_rvalid0", bus.rvalid_0, 0);
    check("mid_rdata0", bus.rdata_0, 0);
    check("mid_en", bus.bram_en, 0);
    check("mid_addr", bus.bram_addr, 0);
    check("mid_gnt0_blocked", bus.gnt_0, 0);
    check("mid_gnt1_blocked", bus.gnt_1, 0);
    tick();
    settle();
    check("mid_tie_gnt0", bus.gnt_0, 1);
    check("mid_tie_gnt1", bus.gnt_1, 0);
    tick();
    idle_inputs();
    tick();
    tick();

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
